// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART FIFO family.
// Provides the ceiling-log2 constant function, default geometry and the
// occupancy-count width helper used by the FIFO top and its RAM.
package uart_fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 128;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return clog2(depth + 1);
   endfunction

   localparam int DEFAULT_CW = cnt_width(DEFAULT_DEPTH);

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port register array for the UART FIFO.
// Synchronous write, asynchronous read, no reset on the storage so a vendor
// RAM64x18 / LSRAM wrapper with the same ports can be dropped in.
module uart_fifo_ram
   import uart_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage write port; entries are only written when qualified by we.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_sync_param.sv
// Parametrised single-clock FIFO for the CoreUARTapb TX/RX paths.
// Ring buffer with explicit pointer wrap (any DEPTH >= 2), true full at DEPTH,
// occupancy count, threshold/almost flags, synchronous flush and a registered
// data_out that updates on the accepting read edge.
// Optional build macro: UART_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs; without it rejected operations are silently dropped.
module uart_fifo_sync_param
   import uart_fifo_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int AFULL_GAP  = 2,
   parameter int AEMPTY_GAP = 2,
   localparam int CW        = cnt_width(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             write_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             read_n,
   input  logic [CW-1:0]    level,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             geq_level
`ifdef UART_FIFO_ERR_FLAGS_EN
   ,
   output logic             overflow,
   output logic             underflow
`endif
);

   localparam int PW = clog2(DEPTH);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_TH  = (AFULL_GAP >= DEPTH) ? '0 : CW'(DEPTH - AFULL_GAP);
   localparam logic [CW-1:0] AEMPTY_TH = (AEMPTY_GAP >= DEPTH) ? CNT_FULL : CW'(AEMPTY_GAP);
   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

   // Pointer advance with explicit wrap so non power-of-two depths work.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;
   logic [WIDTH-1:0] rd_data_p0;
   logic [WIDTH-1:0] data_out_p1;

   assign full         = (count == CNT_FULL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_TH);
   assign almost_empty = (count <= AEMPTY_TH);
   assign geq_level    = (count >= level);

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_acc = ~read_n & ~empty;
   assign wr_acc = ~write_n & (~full | rd_acc);

   uart_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clock (clock),
      .we    (wr_acc & ~flush),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rd_data_p0)
   );

   // Pointer and occupancy control; flush overrides any accepted operation.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ---- stage p0 -> p1: asynchronous RAM read captured on the accepting read edge
   // Read data register; holds across rejected reads and flush.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)              data_out_p1 <= '0;
      else if (rd_acc && !flush) data_out_p1 <= rd_data_p0;
   end

   assign data_out = data_out_p1;

`ifdef UART_FIFO_ERR_FLAGS_EN
   // Sticky error flags, cleared only by flush or reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (~write_n & full & ~rd_acc) overflow  <= 1'b1;
         if (~read_n & empty)           underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_fifo_sync_param.sv
// Self-checking bench for uart_fifo_sync_param (WIDTH=8, DEPTH=5).
// Table of vectors with hand-derived count/flags, plus a queue model for read
// data; extra sequences cover wrap, back-to-back traffic, level==0 and async reset.
// Overflow/underflow checks are built only when UART_FIFO_ERR_FLAGS_EN is defined.
module tb_uart_fifo_sync_param;

   localparam int W  = 8;
   localparam int D  = 5;
   localparam int CW = 3;

   logic          clock;
   logic          reset_n;
   logic          flush;
   logic          write_n;
   logic [W-1:0]  data_in;
   logic          read_n;
   logic [CW-1:0] level;
   logic [W-1:0]  data_out;
   logic [CW-1:0] count;
   logic          full, empty, almost_full, almost_empty, geq_level;
`ifdef UART_FIFO_ERR_FLAGS_EN
   logic          overflow, underflow;
`endif

   uart_fifo_sync_param #(
      .WIDTH      (W),
      .DEPTH      (D),
      .AFULL_GAP  (2),
      .AEMPTY_GAP (2)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .flush        (flush),
      .write_n      (write_n),
      .data_in      (data_in),
      .read_n       (read_n),
      .level        (level),
      .data_out     (data_out),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .geq_level    (geq_level)
`ifdef UART_FIFO_ERR_FLAGS_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] sb_q[$];
   logic [W-1:0] exp_dout;

   typedef struct {
      logic         wn, rn, fl;
      logic [W-1:0] din;
      int           cnt;
      logic         full, empty, af, ae, geq, ovf, unf;
   } vec_t;

   vec_t tv[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
   task automatic step(input logic wn, input logic rn, input logic fl, input logic [W-1:0] din);
      bit m_rd, m_wr;
      write_n = wn;
      read_n  = rn;
      flush   = fl;
      data_in = din;
      m_rd = !rn && (sb_q.size() != 0);
      m_wr = !wn && ((sb_q.size() != D) || m_rd);
      @(posedge clock);
      #1;
      if (fl) sb_q.delete();
      else begin
         if (m_rd) exp_dout = sb_q.pop_front();
         if (m_wr) sb_q.push_back(din);
      end
      chk("count", 32'(count), 32'(sb_q.size()));
      chk("data_out", 32'(data_out), 32'(exp_dout));
   endtask

   initial begin
      //             wn    rn    fl    din    cnt full empty af  ae  geq ovf unf
      tv[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 0};
      tv[1]  = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 0, 0, 0, 1, 0, 0, 0};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 8'h33, 3, 0, 0, 1, 0, 1, 0, 0};
      tv[3]  = '{1'b0, 1'b1, 1'b0, 8'h44, 4, 0, 0, 1, 0, 1, 0, 0};
      tv[4]  = '{1'b0, 1'b1, 1'b0, 8'h55, 5, 1, 0, 1, 0, 1, 0, 0};
      tv[5]  = '{1'b0, 1'b1, 1'b0, 8'hEE, 5, 1, 0, 1, 0, 1, 1, 0};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 5, 1, 0, 1, 0, 1, 1, 0};
      tv[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 4, 0, 0, 1, 0, 1, 1, 0};
      tv[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3, 0, 0, 1, 0, 1, 1, 0};
      tv[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2, 0, 0, 0, 1, 0, 1, 0};
      tv[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0};
      tv[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0};
      tv[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 1};
      tv[13] = '{1'b0, 1'b0, 1'b0, 8'h66, 1, 0, 0, 0, 1, 0, 1, 1};
      tv[14] = '{1'b0, 1'b1, 1'b0, 8'h77, 2, 0, 0, 0, 1, 0, 1, 1};
      tv[15] = '{1'b0, 1'b0, 1'b1, 8'h88, 0, 0, 1, 0, 1, 0, 0, 0};
      tv[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1};

      reset_n  = 1'b0;
      flush    = 1'b0;
      write_n  = 1'b1;
      read_n   = 1'b1;
      data_in  = '0;
      level    = 3'd3;
      exp_dout = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_aempty", 32'(almost_empty), 1);
      chk("rst_geq", 32'(geq_level), 0);
      chk("rst_dout", 32'(data_out), 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Fill, overflow, full bypass, drain, empty corners, flush priority.
      for (int i = 0; i < 17; i++) begin
         step(tv[i].wn, tv[i].rn, tv[i].fl, tv[i].din);
         chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].cnt));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].full));
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].empty));
         chk($sformatf("v%0d_afull", i), 32'(almost_full), 32'(tv[i].af));
         chk($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(tv[i].ae));
         chk($sformatf("v%0d_geq", i), 32'(geq_level), 32'(tv[i].geq));
`ifdef UART_FIFO_ERR_FLAGS_EN
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tv[i].ovf));
         chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(tv[i].unf));
`endif
      end

      // level == 0 makes geq_level true even when empty.
      level = 3'd0;
      #1;
      chk("geq_level0", 32'(geq_level), 1);
      level = 3'd3;

      // Wrap: 13 write/read pairs, pointers pass DEPTH-1 several times.
      for (int i = 0; i < 13; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'(i));
         step(1'b1, 1'b0, 1'b0, 8'h00);
         chk($sformatf("wrap%0d_data", i), 32'(data_out), 32'(i));
         chk($sformatf("wrap%0d_cnt", i), 32'(count), 0);
      end

      // Sustained simultaneous traffic at partial occupancy.
      step(1'b0, 1'b1, 1'b0, 8'hC0);
      step(1'b0, 1'b1, 1'b0, 8'hC1);
      for (int i = 2; i < 12; i++) step(1'b0, 1'b0, 1'b0, 8'(8'hC0 + i));
      chk("b2b_level", 32'(count), 2);

      // Asynchronous reset mid-traffic, no clock edge needed.
      step(1'b0, 1'b1, 1'b0, 8'h5A);
      write_n = 1'b0;
      read_n  = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_empty", 32'(empty), 1);
      chk("arst_full", 32'(full), 0);
      chk("arst_dout", 32'(data_out), 0);
`ifdef UART_FIFO_ERR_FLAGS_EN
      chk("arst_ovf", 32'(overflow), 0);
`endif
      write_n = 1'b1;
      read_n  = 1'b1;
      sb_q.delete();
      exp_dout = '0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      step(1'b0, 1'b1, 1'b0, 8'h3C);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("post_rst_data", 32'(data_out), 32'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
